sap_datapath: RTL
=================

// Module: sap_datapath
// PURPOSE
// - SAP-1 datapath: executes the control strobes issued each step by the SAP-1 controller.
// - Holds PC, MAR, 16x8 RAM, IR, ACC, BR, OPR and the ALU around one shared 8-bit bus.
// - Returns the current opcode IR[7:4] to the controller and exposes OPR, halt and bus-error status.
// PARAMETERS
// DATA_W   8   bus, RAM word, ACC, BR, IR and OPR width
// ADDR_W   4   PC, MAR and IR operand width; RAM depth is 2**ADDR_W
// OPC_W    4   opcode width, IR[DATA_W-1 -: OPC_W]
// PORTS
// clock        in   1       single clock; all state updates on posedge
// reset        in   1       synchronous, active-high
// PC_OUT, PC_INC, JMP, ACC_IN, ACC_OUT, MAR_IN, RAM_OUT, RAM_IN  in  1 each  controller strobes
// ALU_OUT, ADD_SUB, XOR_NOT, ALU0, ALU1, BR_IN, OPR_IN, IR_IN, IR_OUT, HLT  in  1 each  controller strobes
// prog_we      in   1       RAM program write; honoured only while reset=1
// prog_addr    in   ADDR_W  program write address
// prog_data    in   DATA_W  program write data
// instrucao    out  OPC_W   IR[7:4] to the controller
// opr_out      out  DATA_W  output register OPR
// halted       out  1       sticky; set by HLT
// bus_err      out  1       sticky; set by a multi-driver bus cycle
// bus_dbg      out  DATA_W  current bus value (combinational)
// BEHAVIOUR
// - Timing: the controller updates strobes on negedge. The datapath samples the strobes and the bus on posedge.
// - Reset (reset=1 at posedge): PC, MAR, IR, ACC, BR, OPR, halted and bus_err all go to 0.
//   - RAM is not cleared; prog_we writes ram[prog_addr] <= prog_data.
//   - All strobes are ignored during reset.
// - Bus drivers, combinational:
//   - PC_OUT drives {0,PC}; IR_OUT drives {0,IR[3:0]}; RAM_OUT drives ram[MAR] using the current MAR; ACC_OUT drives ACC; ALU_OUT drives alu_y.
//   - With no driver, the bus is 0.
//   - With two or more drivers, the bus is 0, bus_err is set at that posedge, and all consumers still load 0.
// - Consumers at posedge, when not halted:
//   - MAR_IN: MAR <= bus[3:0].
//   - IR_IN: IR <= bus.
//   - ACC_IN: ACC <= bus.
//   - BR_IN: BR <= bus.
//   - OPR_IN: OPR <= bus.
//   - RAM_IN: ram[MAR] <= bus, using MAR before any same-cycle MAR_IN.
// - PC:
//   - JMP: PC <= bus[3:0]. JMP overrides a simultaneous PC_INC.
//   - Otherwise PC_INC: PC <= PC+1, wrapping 15->0.
// - RAM_OUT together with RAM_IN: the old word is read onto the bus and written back unchanged. This is legal.
// - ALU, combinational, alu_y selected by {ALU1,ALU0}:
//   - 00: ADD_SUB=0 gives ACC+BR; ADD_SUB=1 gives ACC-BR. Result is mod 2**DATA_W; no carry is kept.
//   - 01: ACC & BR.
//   - 10: ACC | BR.
//   - 11: XOR_NOT=0 gives ACC ^ BR; XOR_NOT=1 gives ~ACC.
// - HLT: halted <= 1 at that posedge.
//   - From the next posedge, every strobe is ignored and all registers and RAM freeze.
//   - Only reset clears halted.
// - Reset mid-instruction: state is cleared on that edge. Any concurrent strobe effect is discarded, including RAM_IN.
// - instrucao is always IR[7:4], including while halted.
// STRUCTURE
// - Shared package sap_pkg:
//   - Opcode constants: LDA=1, LDI=2, STA=3, ADD=4, SUB=5, AND=6, OR=7, XOR=8, NOT=9, JMP=A, OUT=E, HLT=F.
//   - ALU select encoding {ALU1,ALU0,XOR_NOT,ADD_SUB}.
//   - DATA_W and ADDR_W defaults.
// - One sub-module, sap_alu: inputs a, b and the 4 select bits; output y. Purely combinational.
// - The bus mux, driver count / bus_err logic, registers and RAM array stay in sap_datapath.
// TESTING
// - Reset with prog_we loading ram[0]=8'h1E, ram[E]=8'h05, then one fetch (PC_OUT+MAR_IN; RAM_OUT+IR_IN+PC_INC) -> IR=8'h1E, instrucao=4'h1, PC=1.
// - LDA E then ADD: ACC=5, BR<=ram[F]=8'hFD, then ALU_OUT+ACC_IN -> ACC=8'h02 (wrap). With ADD_SUB=1 -> ACC=8'h08.
// - AND/OR/XOR/NOT with ACC=8'hC3, BR=8'h5A, via RAM_IN at MAR=7:
//   - AND -> ram[7]=8'h42; OR -> 8'hDB; XOR -> 8'h99.
//   - NOT with ACC_IN -> ACC=8'h3C.
// - PC=15 with PC_INC -> PC=0. JMP+PC_INC with IR[3:0]=9 -> PC=9.
// - PC_OUT+ACC_OUT together with ACC_IN -> bus_dbg=0, ACC=0, bus_err=1; bus_err stays 1 until reset.
// - HLT, then PC_INC/ACC_IN/RAM_IN strobes -> halted=1 and all state unchanged. Then reset -> halted=0, PC=0, RAM contents kept.

Source files
------------

// File: rtl/sap_pkg.sv
// Shared SAP-1 definitions: default widths, opcode values, ALU select encoding
// and the bus multi-driver helper.
package sap_pkg;

  localparam int SAP_DATA_W = 8;
  localparam int SAP_ADDR_W = 4;
  localparam int SAP_OPC_W  = 4;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_LDI = 4'h2;
  localparam logic [3:0] OP_STA = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_NOT = 4'h9;
  localparam logic [3:0] OP_JMP = 4'hA;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Select word is {ALU1, ALU0, XOR_NOT, ADD_SUB}
  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0100,
    ALU_OR  = 4'b1000,
    ALU_XOR = 4'b1100,
    ALU_NOT = 4'b1110
  } alu_sel_e;

  localparam int NUM_DRV = 5;

  function automatic logic multi_hot(input logic [NUM_DRV-1:0] v);
    return (v & (v - NUM_DRV'(1))) != '0;
  endfunction

endpackage

// File: rtl/sap_datapath_alu.sv
// SAP-1 ALU: purely combinational, result modulo 2**DATA_W with no carry kept.
module sap_alu
  import sap_pkg::*;
#(
  parameter int DATA_W = SAP_DATA_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              alu1,
  input  logic              alu0,
  input  logic              xor_not,
  input  logic              add_sub,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = '0;
    unique case ({alu1, alu0})
      2'b00:   y = add_sub ? (a - b) : (a + b);
      2'b01:   y = a & b;
      2'b10:   y = a | b;
      default: y = xor_not ? ~a : (a ^ b);
    endcase
  end

endmodule

// File: rtl/sap_datapath.sv
// SAP-1 datapath: registers, program RAM and ALU around one shared bus,
// driven by controller strobes sampled on the rising clock edge.
module sap_datapath
  import sap_pkg::*;
#(
  parameter int DATA_W = SAP_DATA_W,
  parameter int ADDR_W = SAP_ADDR_W,
  parameter int OPC_W  = SAP_OPC_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              PC_OUT,
  input  logic              PC_INC,
  input  logic              JMP,
  input  logic              ACC_IN,
  input  logic              ACC_OUT,
  input  logic              MAR_IN,
  input  logic              RAM_OUT,
  input  logic              RAM_IN,
  input  logic              ALU_OUT,
  input  logic              ADD_SUB,
  input  logic              XOR_NOT,
  input  logic              ALU0,
  input  logic              ALU1,
  input  logic              BR_IN,
  input  logic              OPR_IN,
  input  logic              IR_IN,
  input  logic              IR_OUT,
  input  logic              HLT,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [OPC_W-1:0]  instrucao,
  output logic [DATA_W-1:0] opr_out,
  output logic              halted,
  output logic              bus_err,
  output logic [DATA_W-1:0] bus_dbg
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [ADDR_W-1:0] pc_q, pc_d, mar_q, mar_d;
  logic [DATA_W-1:0] ir_q, ir_d, acc_q, acc_d, br_q, br_d, opr_q, opr_d;
  logic              halted_q, halted_d, bus_err_q, bus_err_d;

  logic [DATA_W-1:0] ram_q [DEPTH];
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic [DATA_W-1:0] alu_y;
  logic [DATA_W-1:0] bus, bus_or;
  logic [NUM_DRV-1:0] drv_en;
  logic [DATA_W-1:0] drv_val   [NUM_DRV];
  logic [DATA_W-1:0] drv_gated [NUM_DRV];
  logic              multi_drv;

  sap_alu #(.DATA_W(DATA_W)) u_alu (
    .a       (acc_q),
    .b       (br_q),
    .alu1    (ALU1),
    .alu0    (ALU0),
    .xor_not (XOR_NOT),
    .add_sub (ADD_SUB),
    .y       (alu_y)
  );

  assign ram_rdata = ram_q[mar_q];

  assign drv_en     = {ALU_OUT, ACC_OUT, RAM_OUT, IR_OUT, PC_OUT};
  assign drv_val[0] = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
  assign drv_val[1] = {{(DATA_W-ADDR_W){1'b0}}, ir_q[ADDR_W-1:0]};
  assign drv_val[2] = ram_rdata;
  assign drv_val[3] = acc_q;
  assign drv_val[4] = alu_y;

  for (genvar gi = 0; gi < NUM_DRV; gi++) begin : g_drv
    assign drv_gated[gi] = drv_en[gi] ? drv_val[gi] : '0;
  end

  // A contended bus reads as zero so every consumer loads a known value.
  assign multi_drv = multi_hot(drv_en);

  always_comb begin
    bus_or = '0;
    for (int i = 0; i < NUM_DRV; i++) begin
      bus_or = bus_or | drv_gated[i];
    end
  end

  assign bus = multi_drv ? '0 : bus_or;

  always_comb begin
    pc_d      = pc_q;
    mar_d     = mar_q;
    ir_d      = ir_q;
    acc_d     = acc_q;
    br_d      = br_q;
    opr_d     = opr_q;
    halted_d  = halted_q;
    bus_err_d = bus_err_q;
    ram_we    = 1'b0;
    ram_waddr = mar_q;
    ram_wdata = bus;
    if (reset) begin
      ram_we    = prog_we;
      ram_waddr = prog_addr;
      ram_wdata = prog_data;
    end else if (!halted_q) begin
      if (MAR_IN) mar_d = bus[ADDR_W-1:0];
      if (IR_IN)  ir_d  = bus;
      if (ACC_IN) acc_d = bus;
      if (BR_IN)  br_d  = bus;
      if (OPR_IN) opr_d = bus;
      if (JMP) begin
        pc_d = bus[ADDR_W-1:0];
      end else if (PC_INC) begin
        pc_d = pc_q + 1'b1;
      end
      // Write address is the pre-edge MAR, so a same-cycle MAR_IN does not redirect it.
      if (RAM_IN)    ram_we    = 1'b1;
      if (HLT)       halted_d  = 1'b1;
      if (multi_drv) bus_err_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q      <= '0;
      mar_q     <= '0;
      ir_q      <= '0;
      acc_q     <= '0;
      br_q      <= '0;
      opr_q     <= '0;
      halted_q  <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      mar_q     <= mar_d;
      ir_q      <= ir_d;
      acc_q     <= acc_d;
      br_q      <= br_d;
      opr_q     <= opr_d;
      halted_q  <= halted_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_ff @(posedge clock) begin
    if (ram_we) ram_q[ram_waddr] <= ram_wdata;
  end

  assign instrucao = ir_q[DATA_W-1 -: OPC_W];
  assign opr_out   = opr_q;
  assign halted    = halted_q;
  assign bus_err   = bus_err_q;
  assign bus_dbg   = bus;

endmodule
